// File: rtl/pio_mailbox_responder.sv
// pio_mailbox_responder
//   FPGA-side endpoint of the HPS PIO mailbox. The host writes 20-bit command words with a
//   toggle bit. Each new command is either answered locally (NOP echo, STATUS) or handed to
//   the border-detection core. A 32-bit result word carrying the echoed toggle comes back.
//
// Ports
//   clk        fabric clock
//   reset_n    asynchronous active-low reset
//   pio_in     [19] req toggle, [18:16] opcode, [15:0] payload
//   hps_done   level-high host abort/idle
//   pio_out    [31] ack toggle, [30] err, [29:0] data
//   cmd_valid  command to core valid
//   cmd_ready  core accepts command
//   cmd_op     opcode to core
//   cmd_data   payload to core
//   rsp_valid  single-cycle core result strobe
//   rsp_data   core result
//   rsp_err    core error flag
module pio_mailbox_responder #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [19:0] pio_in,
  input  logic        hps_done,
  output logic [31:0] pio_out,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [2:0]  cmd_op,
  output logic [15:0] cmd_data,
  input  logic        rsp_valid,
  input  logic [29:0] rsp_data,
  input  logic        rsp_err
);

  localparam int unsigned TmoW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0] OpNop    = 3'd0;
  localparam logic [2:0] OpStatus = 3'd7;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StRespond} state_e;

  state_e            state_q, state_d;
  logic [19:0]       pio_in_q;
  logic              tog_prev_q;
  logic              last_ack_q, last_ack_d;
  logic              req_tog_q, req_tog_d;
  logic [2:0]        op_q, op_d;
  logic [15:0]       payload_q, payload_d;
  logic              res_err_q, res_err_d;
  logic [29:0]       res_data_q, res_data_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic [CNT_W-1:0]  txn_cnt_q, txn_cnt_d;
  logic              overrun_q, overrun_d;
  logic [31:0]       pio_out_q, pio_out_d;

  logic        new_req;
  logic        tmo_hit;
  logic [29:0] status_word;
  logic        rsp_word_err;
  logic [29:0] rsp_word_data;

  assign new_req = (state_q == StIdle) && (pio_in_q[19] != last_ack_q);
  assign tmo_hit = (tmo_q == TmoLast);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (new_req) begin
          if (pio_in_q[18:16] == OpNop || pio_in_q[18:16] == OpStatus) begin
            state_d = StRespond;
          end else begin
            state_d = StIssue;
          end
        end
      end
      StIssue:   if (cmd_ready) state_d = StWait;
      StWait:    if (rsp_valid || tmo_hit) state_d = StRespond;
      StRespond: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
    // Host abort overrides everything
    if (hps_done) state_d = StIdle;
  end

  // Outputs
  always_comb begin
    cmd_valid = (state_q == StIssue);
    cmd_op    = op_q;
    cmd_data  = payload_q;
    pio_out   = pio_out_q;
  end

  // Result word assembled in RESPOND
  always_comb begin
    status_word              = '0;
    status_word[CNT_W-1:0]   = txn_cnt_q;
    status_word[29]          = overrun_q;
    if (op_q == OpNop) begin
      rsp_word_err  = 1'b0;
      rsp_word_data = {14'd0, payload_q};
    end else if (op_q == OpStatus) begin
      rsp_word_err  = 1'b0;
      rsp_word_data = status_word;
    end else begin
      rsp_word_err  = res_err_q;
      rsp_word_data = res_data_q;
    end
  end

  // Datapath next-state
  always_comb begin
    last_ack_d = last_ack_q;
    req_tog_d  = req_tog_q;
    op_d       = op_q;
    payload_d  = payload_q;
    res_err_d  = res_err_q;
    res_data_d = res_data_q;
    tmo_d      = tmo_q;
    txn_cnt_d  = txn_cnt_q;
    overrun_d  = overrun_q;
    pio_out_d  = pio_out_q;

    unique case (state_q)
      StIdle: begin
        if (new_req) begin
          req_tog_d = pio_in_q[19];
          op_d      = pio_in_q[18:16];
          payload_d = pio_in_q[15:0];
        end
      end
      StIssue: begin
        if (cmd_ready) tmo_d = '0;
      end
      StWait: begin
        tmo_d = tmo_q + TmoW'(1);
        // A response arriving on the timeout cycle still counts as a normal response
        if (rsp_valid) begin
          res_err_d  = rsp_err;
          res_data_d = rsp_data;
        end else if (tmo_hit) begin
          res_err_d  = 1'b1;
          res_data_d = '0;
        end
      end
      StRespond: begin
        pio_out_d  = {req_tog_q, rsp_word_err, rsp_word_data};
        last_ack_d = req_tog_q;
        txn_cnt_d  = txn_cnt_q + CNT_W'(1);
        if (op_q == OpStatus) overrun_d = 1'b0;
      end
      default: ;
    endcase

    // Host toggled while busy: flag it, the request itself is dropped
    if (state_q != StIdle && pio_in_q[19] != tog_prev_q) overrun_d = 1'b1;

    if (hps_done) begin
      pio_out_d  = '0;
      last_ack_d = pio_in_q[19];
      txn_cnt_d  = '0;
      overrun_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pio_in_q   <= '0;
      tog_prev_q <= 1'b0;
      last_ack_q <= 1'b0;
      req_tog_q  <= 1'b0;
      op_q       <= '0;
      payload_q  <= '0;
      res_err_q  <= 1'b0;
      res_data_q <= '0;
      tmo_q      <= '0;
      txn_cnt_q  <= '0;
      overrun_q  <= 1'b0;
      pio_out_q  <= '0;
    end else begin
      pio_in_q   <= pio_in;
      tog_prev_q <= pio_in_q[19];
      last_ack_q <= last_ack_d;
      req_tog_q  <= req_tog_d;
      op_q       <= op_d;
      payload_q  <= payload_d;
      res_err_q  <= res_err_d;
      res_data_q <= res_data_d;
      tmo_q      <= tmo_d;
      txn_cnt_q  <= txn_cnt_d;
      overrun_q  <= overrun_d;
      pio_out_q  <= pio_out_d;
    end
  end

endmodule

// File: tb/tb_pio_mailbox_responder.sv
// Directed bench for pio_mailbox_responder (TIMEOUT_CYCLES=16, CNT_W=4).
module tb_pio_mailbox_responder;

  localparam int unsigned Tmo = 16;

  logic        clk;
  logic        reset_n;
  logic [19:0] pio_in;
  logic        hps_done;
  logic [31:0] pio_out;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [15:0] cmd_data;
  logic        rsp_valid;
  logic [29:0] rsp_data;
  logic        rsp_err;

  pio_mailbox_responder #(
    .TIMEOUT_CYCLES(Tmo),
    .CNT_W         (4)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .pio_in   (pio_in),
    .hps_done (hps_done),
    .pio_out  (pio_out),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_data (cmd_data),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .rsp_err  (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] cur_out;

  typedef struct {
    logic [19:0] pin;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Local op: pio_out must hold for two edges and update on the third
  task automatic apply_local(input string name, input logic [19:0] pin, input logic [31:0] exp);
    pio_in = pin;
    tick();
    check({name, " cmd_valid"}, {31'd0, cmd_valid}, 32'd0);
    tick();
    check({name, " held"}, pio_out, cur_out);
    tick();
    check(name, pio_out, exp);
    check({name, " cmd_valid"}, {31'd0, cmd_valid}, 32'd0);
    cur_out = exp;
  endtask

  // Core op up to the first WAIT cycle
  task automatic core_req(input string name, input logic [19:0] pin, input logic [2:0] op);
    pio_in = pin;
    tick();
    tick();
    check({name, " cmd_valid"}, {31'd0, cmd_valid}, 32'd1);
    check({name, " cmd_op"}, {29'd0, cmd_op}, {29'd0, op});
    check({name, " cmd_data"}, {16'd0, cmd_data}, {16'd0, pin[15:0]});
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    check({name, " cmd_valid drop"}, {31'd0, cmd_valid}, 32'd0);
  endtask

  task automatic pulse_rsp(input logic err, input logic [29:0] data);
    rsp_valid = 1'b1;
    rsp_err   = err;
    rsp_data  = data;
    tick();
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_data  = '0;
  endtask

  initial begin
    vecs[0] = '{pin: 20'h8_1234, exp: 32'h8000_1234};
    vecs[1] = '{pin: 20'h0_BEEF, exp: 32'h0000_BEEF};
    vecs[2] = '{pin: 20'hF_0000, exp: 32'h8000_0002};  // STATUS, 2 done
    vecs[3] = '{pin: 20'h0_FFFF, exp: 32'h0000_FFFF};
    vecs[4] = '{pin: 20'h8_0000, exp: 32'h8000_0000};
    vecs[5] = '{pin: 20'h7_1111, exp: 32'h0000_0005};  // STATUS, 5 done

    reset_n   = 1'b0;
    pio_in    = '0;
    hps_done  = 1'b0;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_data  = '0;
    rsp_err   = 1'b0;
    cur_out   = '0;
    #12;
    check("reset pio_out", pio_out, 32'd0);
    check("reset cmd_valid", {31'd0, cmd_valid}, 32'd0);
    check("reset cmd_op", {29'd0, cmd_op}, 32'd0);
    check("reset cmd_data", {16'd0, cmd_data}, 32'd0);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      apply_local($sformatf("vec%0d", i), vecs[i].pin, vecs[i].exp);
    end

    // Core op: same toggle first, no request expected
    pio_in = 20'h1_00AB;
    repeat (4) tick();
    check("no req cmd_valid", {31'd0, cmd_valid}, 32'd0);
    check("no req pio_out", pio_out, cur_out);
    pio_in = 20'h9_00AB;
    tick();
    check("core pre cmd_valid", {31'd0, cmd_valid}, 32'd0);
    tick();
    check("core cmd_valid", {31'd0, cmd_valid}, 32'd1);
    check("core cmd_op", {29'd0, cmd_op}, 32'd1);
    check("core cmd_data", {16'd0, cmd_data}, 32'h0000_00AB);
    repeat (4) tick();
    check("core stall cmd_valid", {31'd0, cmd_valid}, 32'd1);
    check("core stall cmd_data", {16'd0, cmd_data}, 32'h0000_00AB);
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    check("core accepted", {31'd0, cmd_valid}, 32'd0);
    repeat (3) tick();
    pulse_rsp(1'b0, 30'h155);
    check("core respond held", pio_out, cur_out);
    tick();
    check("core result", pio_out, 32'h8000_0155);
    cur_out = 32'h8000_0155;

    apply_local("nop55", 20'h0_0055, 32'h0000_0055);

    // Timeout
    core_req("tmo", 20'hA_0000, 3'd2);
    repeat (Tmo) tick();
    check("tmo not yet", pio_out, cur_out);
    tick();
    check("tmo result", pio_out, 32'hC000_0000);
    cur_out = 32'hC000_0000;
    repeat (4) tick();
    pulse_rsp(1'b0, 30'h3FF);
    repeat (2) tick();
    check("late rsp ignored", pio_out, 32'hC000_0000);
    check("late rsp cmd_valid", {31'd0, cmd_valid}, 32'd0);

    // Response on the final timeout cycle wins
    core_req("edge", 20'h3_0001, 3'd3);
    repeat (Tmo - 1) tick();
    pulse_rsp(1'b0, 30'h2A);
    tick();
    check("rsp at timeout", pio_out, 32'h0000_002A);
    cur_out = 32'h0000_002A;

    // Overrun: two toggles during WAIT
    core_req("ovr", 20'hC_0009, 3'd4);
    pio_in = 20'h4_0009;
    repeat (2) tick();
    pio_in = 20'hC_0009;
    repeat (2) tick();
    pulse_rsp(1'b1, 30'h77);
    tick();
    check("ovr txn result", pio_out, 32'hC000_0077);
    cur_out = 32'hC000_0077;
    apply_local("status ovr", 20'h7_0000, 32'h2000_000B);
    apply_local("status clr", 20'hF_0000, 32'h8000_000C);

    // Abort during WAIT
    core_req("abort", 20'h5_0003, 3'd5);
    repeat (2) tick();
    hps_done = 1'b1;
    tick();
    check("abort pio_out", pio_out, 32'd0);
    check("abort cmd_valid", {31'd0, cmd_valid}, 32'd0);
    rsp_valid = 1'b1;
    rsp_data  = 30'h99;
    tick();
    rsp_valid = 1'b0;
    rsp_data  = '0;
    hps_done  = 1'b0;
    repeat (2) tick();
    check("abort rsp ignored", pio_out, 32'd0);
    check("abort idle cmd_valid", {31'd0, cmd_valid}, 32'd0);
    cur_out = 32'd0;
    apply_local("status after abort", 20'hF_0000, 32'h8000_0000);

    // Counter wrap at 16
    hps_done = 1'b1;
    tick();
    hps_done = 1'b0;
    tick();
    cur_out = 32'd0;
    for (int i = 0; i < 16; i++) begin
      logic        tog;
      logic [15:0] pl;
      tog = (i % 2 == 1);
      pl  = 16'(i * 16'h0111);
      apply_local($sformatf("wrap nop%0d", i), {tog, 3'd0, pl}, {tog, 15'd0, pl});
    end
    apply_local("status wrap", 20'h7_0000, 32'h0000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
